// File: rtl/vm_pkg.sv
// vm_pkg: shared coin denominations, state encoding and value lookup for the money accumulator.
package vm_pkg;
  localparam int DENOM_1 = 0;
  localparam int DENOM_5 = 1;
  localparam int DENOM_10 = 2;
  localparam int DENOM_20 = 3;
  localparam int NUM_KNOWN = 4;
  localparam int DENOM_VAL [NUM_KNOWN] = '{1, 5, 10, 20};
  typedef enum logic {IDLE, DISPENSE} state_t;
  // Selects outside the configured or known set are worth nothing.
  function automatic int denom_val(int sel, int num);
    return (sel >= 0 && sel < num && sel < NUM_KNOWN) ? DENOM_VAL[sel] : 0;
  endfunction
endpackage

// File: rtl/change_selector.sv
// change_selector: greedy pick of the largest denomination not exceeding the credit.
module change_selector
  import vm_pkg::*;
#(
  parameter int CREDIT_W = 8,
  parameter int NUM_DENOM = 4,
  parameter int SEL_W = $clog2(NUM_DENOM)
) (
  input  logic [CREDIT_W-1:0] credit,
  output logic [SEL_W-1:0]    sel,
  output logic [CREDIT_W-1:0] value
);
  always_comb begin
    sel = '0;
    value = '0;
    for (int i = 0; i < NUM_DENOM; i++)
      if (denom_val(i, NUM_DENOM) != 0 && CREDIT_W'(denom_val(i, NUM_DENOM)) <= credit) begin
        sel = SEL_W'(i);
        value = CREDIT_W'(denom_val(i, NUM_DENOM));
      end
  end
endmodule

// File: rtl/money_accumulator.sv
// money_accumulator: coin credit register with purchase settlement and greedy change payout.
// Define AUTO_CHANGE_EN to pay out the remainder of a successful purchase automatically.
module money_accumulator
  import vm_pkg::*;
#(
  parameter int CREDIT_W = 8,
  parameter int MAX_CREDIT = 200,
  parameter int NUM_DENOM = 4,
  parameter int SEL_W = $clog2(NUM_DENOM)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                coin_valid_i,
  input  logic [SEL_W-1:0]    coin_sel_i,
  output logic                coin_ready_o,
  output logic                coin_reject_o,
  input  logic [CREDIT_W-1:0] price_i,
  input  logic                buy_req_i,
  output logic                buy_ack_o,
  output logic                buy_fail_o,
  input  logic                refund_req_i,
  output logic                change_valid_o,
  output logic [SEL_W-1:0]    change_sel_o,
  input  logic                change_ready_i,
  output logic                busy_o,
  output logic [CREDIT_W-1:0] credit_o
);
  state_t state, state_n;
  logic [CREDIT_W-1:0] credit, credit_n, chg_val, coin_val;
  logic [SEL_W-1:0] chg_sel;
  logic [CREDIT_W:0] coin_sum;
  logic rej_n, ack_n, fail_n;

  change_selector #(.CREDIT_W(CREDIT_W), .NUM_DENOM(NUM_DENOM), .SEL_W(SEL_W)) u_sel (
    .credit(credit),
    .sel(chg_sel),
    .value(chg_val)
  );

  assign coin_val = CREDIT_W'(denom_val(int'(coin_sel_i), NUM_DENOM));
  assign coin_sum = {1'b0, credit} + {1'b0, coin_val};
  assign coin_ready_o = state == IDLE;
  assign busy_o = state == DISPENSE;
  assign change_valid_o = busy_o;
  assign change_sel_o = busy_o ? chg_sel : '0;
  assign credit_o = credit;

  always_comb begin
    state_n = state;
    credit_n = credit;
    rej_n = 1'b0;
    ack_n = 1'b0;
    fail_n = 1'b0;
    if (state == DISPENSE) begin
      if (change_ready_i) begin
        credit_n = credit - chg_val;
        state_n = (credit_n == '0) ? IDLE : DISPENSE;
      end
    end else if (refund_req_i) begin
      state_n = (credit != '0) ? DISPENSE : IDLE;
    end else if (buy_req_i) begin
      if (credit >= price_i) begin
        credit_n = credit - price_i;
        ack_n = 1'b1;
`ifdef AUTO_CHANGE_EN
        state_n = (credit_n != '0) ? DISPENSE : IDLE;
`else
        state_n = IDLE;
`endif
      end else fail_n = 1'b1;
    end else if (coin_valid_i) begin
      // Sum is one bit wider so an overflowing coin cannot wrap past the guard.
      if (coin_sum <= (CREDIT_W+1)'(MAX_CREDIT)) credit_n = coin_sum[CREDIT_W-1:0];
      else rej_n = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      credit <= '0;
      coin_reject_o <= 1'b0;
      buy_ack_o <= 1'b0;
      buy_fail_o <= 1'b0;
    end else begin
      state <= state_n;
      credit <= credit_n;
      coin_reject_o <= rej_n;
      buy_ack_o <= ack_n;
      buy_fail_o <= fail_n;
    end
  end
endmodule

// File: doc/money_accumulator.md
Name: money_accumulator

Overview:
- Sequential, parametrised successor to the vending machine's combinational coin-sum stage.
- Accepts one coin event per cycle and accumulates credit in a register, with an overflow guard.
- Settles purchases against a price, and pays out change coin-by-coin over a valid/ready handshake.
- Sits between the coin acceptor front end and the product-dispense controller.

Parameters:
- CREDIT_W, 8: width of credit, price and value datapaths.
- MAX_CREDIT, 200: highest credit the block may hold; must be < 2**CREDIT_W.
- NUM_DENOM, 4: number of coin denominations; coin and change selects are $clog2(NUM_DENOM) bits wide (SEL_W).

Ports:
- clk_i, in, 1: single clock.
- rst_i, in, 1: reset, synchronous, active-high.
- coin_valid_i, in, 1: coin event present this cycle.
- coin_sel_i, in, SEL_W: denomination index of the coin (0=1, 1=5, 2=10, 3=20).
- coin_ready_o, out, 1: block can take a coin this cycle.
- coin_reject_o, out, 1: one-cycle pulse; the offered coin would exceed MAX_CREDIT and was not credited.
- price_i, in, CREDIT_W: item price; sampled with buy_req_i.
- buy_req_i, in, 1: purchase request, single-cycle.
- buy_ack_o, out, 1: one-cycle pulse; purchase accepted and price deducted.
- buy_fail_o, out, 1: one-cycle pulse; credit was below the price.
- refund_req_i, in, 1: request to return all credit as change.
- change_valid_o, out, 1: a change coin is offered.
- change_sel_o, out, SEL_W: denomination index of the offered change coin.
- change_ready_i, in, 1: downstream takes the offered change coin.
- busy_o, out, 1: high while in DISPENSE.
- credit_o, out, CREDIT_W: current credit register.

Behaviour:
- Reset: rst_i is sampled on the clk_i edge.
  - Credit is 0 and the state is IDLE.
  - All pulse outputs are 0, as are change_valid_o, change_sel_o and busy_o.
  - coin_ready_o is 1 in the cycle after reset.
- Reset has priority over everything, including mid-dispense. Any in-flight change coin is abandoned and credit is lost.
- States: IDLE and DISPENSE.
- IDLE:
  - coin_ready_o is 1.
  - Per-cycle priority is refund > buy > coin. At most one action executes per cycle; lower-priority requests in that cycle are dropped.
- Refund in IDLE:
  - If credit > 0: go to DISPENSE next cycle.
  - If credit == 0: no-op and stay in IDLE.
- Buy:
  - If credit >= price_i: credit <= credit - price_i and buy_ack_o=1 next cycle.
  - Otherwise credit is unchanged and buy_fail_o=1 next cycle.
  - price_i == 0 always acks.
- Coin:
  - Value v = DENOM_VAL[coin_sel_i]. Compute credit+v at CREDIT_W+1 bits.
  - If credit+v <= MAX_CREDIT: credit <= credit+v.
  - Otherwise credit is unchanged and coin_reject_o=1 next cycle.
  - A coin_sel_i at or above NUM_DENOM has value 0: it is accepted with no credit change.
- Latency: credit_o reflects any action one cycle after the request cycle. All pulses are registered and last exactly one cycle.
- DISPENSE:
  - coin_ready_o=0, busy_o=1. coin, buy and refund inputs are ignored (not queued).
  - change_valid_o=1 with change_sel_o = largest denomination whose value is <= credit (greedy).
  - On change_valid_o && change_ready_i: credit <= credit - value.
  - When the new credit is 0, the next state is IDLE and change_valid_o drops in the same edge.
  - While change_ready_i=0, change_valid_o and change_sel_o hold stable.
- Credit never underflows. With denomination 1 present, greedy change always terminates.

Optional Feature:
- AUTO_CHANGE_EN defined: a successful buy that leaves credit > 0 transitions straight to DISPENSE, returning the remainder without a refund_req_i.
- AUTO_CHANGE_EN undefined: the remaining credit stays in IDLE for further purchases.

Decomposition:
- Package vm_pkg holds:
  - the SEL_W-indexed DENOM_VAL constant array {1,5,10,20};
  - the state enum {IDLE, DISPENSE};
  - the denomination index localparams.
- One natural sub-module, change_selector: purely combinational credit -> (change_sel, value) greedy picker, used by DISPENSE.

Test Plan:
- Reset, then coins 20,10,5,1 on consecutive cycles -> credit_o reads 20, 30, 35, 36 one cycle after each; no coin_reject_o.
- Credit 195, coin 10 -> coin_reject_o pulse, credit 195. Then coin 5 -> credit 200 (MAX_CREDIT).
- Credit 36, price 40 buy -> buy_fail_o, credit 36. Then price 30 buy -> buy_ack_o, credit 6; with AUTO_CHANGE_EN, busy_o=1 next cycle.
- Credit 36, refund with change_ready_i stalled 3 cycles on the first coin -> change_sel_o held at 3 (20). Then coins 20,10,5,1 in order, credit ends 0, busy_o=0.
- Same-cycle refund+buy+coin at credit 30 -> only refund executes: DISPENSE entered, no buy_ack_o, no coin credited.
- rst_i asserted mid-dispense (credit 15, after the first 10 is taken) -> next cycle credit 0, IDLE, change_valid_o=0, coin_ready_o=1.
